// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pll_lock_supervisor : syncs two PLL LOCKs, sequences sys_rst, counts      |
// | loss-of-lock. Optional LOCK_STICKY_ERR_EN adds err_clr/lock_err. Rev 1.0  |
// +--------------------------------------------------------------------------+
module pll_lock_supervisor #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RST_HOLD_CYCLES    = 16,
   parameter int GLITCH_CYCLES      = 3,
   parameter int CNT_W              = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll1_lock,
   input  logic             pll2_lock,
`ifdef LOCK_STICKY_ERR_EN
   input  logic             err_clr,
   output logic             lock_err,
`endif
   output logic             sys_rst,
   output logic             locked,
   output logic [CNT_W-1:0] lock_lost_cnt,
   output logic [2:0]       state
);

   localparam int c_sw = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int c_hw = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
   localparam int c_gw = (GLITCH_CYCLES > 0) ? $clog2(GLITCH_CYCLES + 1) : 1;

   localparam logic [c_sw-1:0] c_stable_last = c_sw'(LOCK_STABLE_CYCLES - 1);
   localparam logic [c_hw-1:0] c_hold_last   = c_hw'(RST_HOLD_CYCLES - 1);
   localparam logic [c_gw-1:0] c_glitch_last = c_gw'(GLITCH_CYCLES);

   typedef enum logic [2:0] {
      ST_WAIT   = 3'd0,
      ST_STABLE = 3'd1,
      ST_HOLD   = 3'd2,
      ST_READY  = 3'd3,
      ST_LOST   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sync1_q, sync2_q;
   logic [c_sw-1:0]  stable_cnt_q, stable_cnt_d;
   logic [c_hw-1:0]  hold_cnt_q, hold_cnt_d;
   logic [c_gw-1:0]  low_cnt_q, low_cnt_d;
   logic [CNT_W-1:0] lost_cnt_q;
   logic             sys_rst_q, locked_q;
   logic             w_both, w_lost_entry;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
      end else begin
         sync1_q <= {sync1_q[0], pll1_lock};
         sync2_q <= {sync2_q[0], pll2_lock};
      end
   end

   assign w_both = sync1_q[1] & sync2_q[1];

   always_comb begin
      state_d      = state_q;
      stable_cnt_d = stable_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      low_cnt_d    = low_cnt_q;
      case (state_q)
         ST_WAIT: begin
            if (w_both) begin
               state_d      = ST_STABLE;
               stable_cnt_d = '0;
            end
         end
         ST_STABLE: begin
            if (!w_both) begin
               state_d = ST_WAIT;
            end else if (stable_cnt_q == c_stable_last) begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
            end else begin
               stable_cnt_d = stable_cnt_q + c_sw'(1);
            end
         end
         ST_HOLD: begin
            if (!w_both) begin
               state_d = ST_WAIT;
            end else if (hold_cnt_q == c_hold_last) begin
               state_d   = ST_READY;
               low_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + c_hw'(1);
            end
         end
         ST_READY: begin
            // Low runs shorter than GLITCH_CYCLES+1 cycles are treated as noise.
            if (w_both) begin
               low_cnt_d = '0;
            end else if (low_cnt_q == c_glitch_last) begin
               state_d = ST_LOST;
            end else begin
               low_cnt_d = low_cnt_q + c_gw'(1);
            end
         end
         ST_LOST: state_d = ST_WAIT;
         default: state_d = ST_WAIT;
      endcase
   end

   assign w_lost_entry = (state_q == ST_READY) && (state_d == ST_LOST);

   // Outputs derive from the next state so they switch on the same edge as the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_WAIT;
         stable_cnt_q <= '0;
         hold_cnt_q   <= '0;
         low_cnt_q    <= '0;
         lost_cnt_q   <= '0;
         sys_rst_q    <= 1'b1;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         stable_cnt_q <= stable_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         low_cnt_q    <= low_cnt_d;
         sys_rst_q    <= (state_d != ST_READY);
         locked_q     <= (state_d == ST_READY);
         if (w_lost_entry && (lost_cnt_q != '1)) begin
            lost_cnt_q <= lost_cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef LOCK_STICKY_ERR_EN
   logic lock_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_err_q <= 1'b0;
      end else if (w_lost_entry) begin
         lock_err_q <= 1'b1;
      end else if (err_clr) begin
         lock_err_q <= 1'b0;
      end
   end

   assign lock_err = lock_err_q;
`endif

   assign sys_rst       = sys_rst_q;
   assign locked        = locked_q;
   assign lock_lost_cnt = lost_cnt_q;
   assign state         = state_q;

endmodule
`default_nettype wire

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumes the asynchronous LOCK outputs of two cascaded iCE40 PLLs and generates the design's synchronous system reset.
- Runs in the PLL-derived system clock domain.
- Holds sys_rst asserted until both locks are synchronized, stable for a programmable time, and a reset-hold period has elapsed.
- In READY, filters short lock glitches and counts genuine loss-of-lock events.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive cycles both locks must stay high before reset hold begins (>=1).
- RST_HOLD_CYCLES, 16: additional cycles sys_rst stays asserted after lock is stable (>=1).
- GLITCH_CYCLES, 3: in READY, low runs of up to this many cycles are ignored (0 = any low is a loss).
- CNT_W, 8: width of the loss-event counter.

Ports:
- clk  input  1  system clock (PLL output domain).
- rst  input  1  synchronous active-high reset.
- pll1_lock  input  1  PLL1 LOCK, asynchronous.
- pll2_lock  input  1  PLL2 LOCK, asynchronous.
- sys_rst  output  1  registered active-high reset for downstream logic.
- locked  output  1  registered; high only in READY.
- lock_lost_cnt  output  CNT_W  saturating count of loss-of-lock events.
- state  output  3  current FSM state (debug).

Behaviour:
- Reset is synchronous and active-high; the clock is clk and the reset is rst. No other clock.
- Reset values: sys_rst=1, locked=0, lock_lost_cnt=0, state=WAIT.
  - Both 2-FF synchronizers clear to 0.
  - All internal counters clear to 0.
- Lock synchronization:
  - Each lock input passes through its own 2-FF synchronizer.
  - both = sync1 & sync2.
  - An input rising at sampling edge k makes both=1 visible to the FSM during the cycle after edge k+1.
- State encoding: WAIT=0, STABLE=1, HOLD=2, READY=3, LOST=4. Codes 5-7 go to WAIT on the next edge.
- WAIT:
  - sys_rst=1, locked=0.
  - If both=1, go to STABLE with stable_cnt=0.
- STABLE:
  - If both=0, go to WAIT.
  - Else if stable_cnt==LOCK_STABLE_CYCLES-1, go to HOLD with hold_cnt=0.
  - Else increment stable_cnt.
  - The state occupies exactly LOCK_STABLE_CYCLES cycles when lock is clean.
- HOLD:
  - sys_rst=1.
  - If both=0, go to WAIT.
  - Else if hold_cnt==RST_HOLD_CYCLES-1, go to READY.
  - Else increment hold_cnt.
- READY:
  - sys_rst=0 and locked=1, both registered and changing on the same edge as the state change.
  - low_cnt increments each cycle both=0 and clears when both=1.
  - The (GLITCH_CYCLES+1)-th consecutive low cycle causes the transition to LOST.
- LOST:
  - On entry, sys_rst=1, locked=0, and lock_lost_cnt increments, saturating at 2^CNT_W-1.
  - LOST lasts exactly 1 cycle, then the FSM goes to WAIT.
- Latency: from edge k (first sample with both inputs high) to sys_rst falling is 2+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES edges.
- Lock dropping in STABLE or HOLD:
  - Return to WAIT immediately.
  - lock_lost_cnt is not incremented.
  - Counters restart from 0 on re-lock.
- rst in any state:
  - All outputs and counters return to reset values on the next edge.
  - rst has priority over all FSM transitions.
- Width rules: counters are sized $clog2 of the relevant parameter, minimum 1 bit. No wrap-around beyond terminal counts.

Optional Feature:
- Macro: LOCK_STICKY_ERR_EN.
- Defined:
  - Adds input err_clr (1 bit) and output lock_err (1 bit, reset 0).
  - lock_err sets on entry to LOST and clears on a cycle with err_clr=1.
  - If LOST entry and err_clr coincide, set wins.
- Undefined:
  - Neither port exists.
  - Behaviour is otherwise identical.

Test Plan:
- Clean lock (N=16, H=8, G=2): both locks rise before sampling edge 0 -> sys_rst=1 through edge 25, sys_rst=0 and locked=1 from edge 26, state=3.
- Partial lock: only pll1_lock high for 200 cycles -> state stays 0, sys_rst=1, locked=0.
- Drop in STABLE (same params): pll2_lock low for 1 cycle at stable_cnt=10, then high -> state returns to 0, lock_lost_cnt=0, sys_rst falls 26 edges after the re-lock sample.
- Glitch filter in READY, G=2:
  - 2-cycle low pulse -> no state change.
  - 3-cycle low pulse -> LOST for 1 cycle, lock_lost_cnt=1, sys_rst=1, then WAIT, re-lock sequence succeeds.
- Saturation and sticky error (CNT_W=2, LOCK_STICKY_ERR_EN defined): 5 loss events -> lock_lost_cnt=3, lock_err=1; err_clr pulse coinciding with a 6th LOST entry -> lock_err stays 1; a later clean err_clr -> lock_err=0.
- Reset mid-HOLD: assert rst at hold_cnt=4 -> next edge state=0, sys_rst=1, locked=0, lock_lost_cnt=0.
